mcp3008_responder: RTL and testbench
====================================

Name: mcp3008_responder

Overview:
- Synthesizable SPI responder that emulates the MCP3008 8-channel 10-bit ADC on the device side of the link driven by mcp3008_interface.
- Oversamples the master's SPI pins on a local system clock, decodes the start and configuration bits, and requests a 10-bit sample from a local data source.
- Shifts the result out on dout using MCP3008 framing.
- Used in loopback self-test builds and as a bench-side device model for the ADC interface.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spi_clk, cs_n and din (minimum 2).
- DATA_W, 10, conversion result width.

Ports:
- clk  input  1  system clock; f_clk >= 8 x f_spi_clk required.
- rst_n  input  1  asynchronous active-low reset.
- spi_clk  input  1  SPI data clock from master (the master's dclk).
- cs_n  input  1  active-low chip select from master.
- din  input  1  master-to-device serial data.
- dout  output  1  device-to-master serial data.
- dout_oe  output  1  dout drive enable; pad tri-states when low.
- ch_sel  output  3  channel requested (D2..D0).
- sgl_diff  output  1  1 = single-ended, 0 = differential (as received).
- ch_data  input  DATA_W  sample value for ch_sel/sgl_diff; source must hold it valid while sample_req is high.
- sample_req  output  1  one-clk pulse; ch_data is captured on this cycle.
- busy  output  1  high from start-bit detect until frame end/abort.
- conv_done  output  1  one-clk pulse after B0 has been driven.

Behaviour:
- Reset: dout=0, dout_oe=0, ch_sel=0, sgl_diff=0, sample_req=0, busy=0, conv_done=0, FSM=IDLE, synchronizers cleared (cs_n sync to 1). Reset is effective at any time, including mid-frame.
- Input path: spi_clk, cs_n, din pass through SYNC_STAGES flops. Rise/fall detect is registered. Every edge action occurs SYNC_STAGES+1 clk after the pin transition.
- Sampling convention: din is sampled on the detected spi_clk rise. dout changes on the detected spi_clk fall.
- dout_oe = synchronized cs_n low. dout=0 whenever FSM is IDLE or WAIT_START.
- IDLE: wait for synchronized cs_n low -> WAIT_START.
- WAIT_START: on each rise, din=0 is a leading zero (ignored, any count); din=1 -> CFG, busy=1, cfg bit count=0.
- CFG: four rises capture sgl_diff, D2, D1, D0 in that order. ch_sel and sgl_diff update on the 4th rise -> SAMPLE.
- SAMPLE: on the next fall, pulse sample_req, capture ch_data into the shift register, drive dout=0 (null bit) -> MSB.
- MSB: on each of the next 10 falls, drive B9..B0.
  - conv_done pulses on the clk the B0 fall is processed.
  - Then LSB (macro on) or ZERO (macro off).
- LSB (macro only): on the next 9 falls, drive B1..B9 (B0 is not repeated) -> ZERO.
- ZERO: dout=0 on all further falls until cs_n rises.
- Abort: synchronized cs_n high in any state -> IDLE on that clk.
  - dout_oe=0, busy=0, dout=0.
  - No conv_done if B0 has not been driven.
  - Captured sample is discarded.
- Simultaneous cs_n rise and spi_clk edge in the same clk: the cs_n rise wins and the edge is ignored.
- cs_n held low after ZERO and new clocks arrive: the block stays in ZERO. A new conversion requires cs_n high for at least 1 synchronized clk.
- Counters are 4 bits. No wrap: a counter saturates at its terminal value, and the state transition occurs on that value.

Optional Feature:
- MCP3008_LSB_FIRST_EN defined: after B0, the LSB-first repeat B1..B9 is emitted, then zeros (matches datasheet 24-clock framing).
- MCP3008_LSB_FIRST_EN not defined: the LSB state is removed, and dout=0 on every fall after B0.

Test Plan:
- Single-ended ch3:
  - Stimulus: cs_n low, din bits 1,1,0,1,1 on rises, ch_data=10'h2A5, f_clk=8x f_spi_clk.
  - Required: ch_sel=3, sgl_diff=1, one sample_req, dout on following falls = 0 then 1,0,1,0,1,0,0,1,0,1, conv_done one pulse, then zeros.
- Leading zeros:
  - Stimulus: three din=0 rises before the start bit, ch 0 differential, ch_data=10'h3FF.
  - Required: sgl_diff=0, ch_sel=0, null bit 0 then ten 1s.
- Abort:
  - Stimulus: cs_n raised after B6 has been driven.
  - Required: dout_oe=0 and busy=0 within SYNC_STAGES+2 clk, no conv_done, next frame decodes correctly.
- Reset mid-frame:
  - Stimulus: rst_n pulsed low during MSB.
  - Required: all outputs at reset values immediately; frame resumes only after a cs_n high->low.
- LSB-first:
  - With MCP3008_LSB_FIRST_EN and ch_data=10'h2A5, after B0 dout = 0,1,0,0,1,0,1,0,1.
  - Without the macro, the same clocks give nine 0s.
- Back-to-back:
  - Stimulus: two frames separated by 10 clk of cs_n high, ch_data 10'h001 then 10'h200.
  - Required: each frame returns its own value, with exactly two sample_req and two conv_done pulses.

Source files
------------

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - MCP3008-style SPI ADC responder (device side of the link)
//
// Oversamples spi_clk/cs_n/din on clk, decodes start + config bits, requests a
// DATA_W-bit sample from the local source and shifts it out MSB first with the
// MCP3008 null bit in front.
//
// Optional build macro: MCP3008_LSB_FIRST_EN
//   defined     : after B0, B1..B9 are repeated LSB first, then zeros
//   not defined : zeros after B0
//
// Ports:
//   clk, rst_n  - system clock (>= 8x spi_clk), async active-low reset
//   spi_clk     - SPI clock from master
//   cs_n        - active-low chip select from master
//   din         - master-to-device serial data (sampled on spi_clk rise)
//   dout        - device-to-master serial data (changes on spi_clk fall)
//   dout_oe     - pad drive enable, high while synchronized cs_n is low
//   ch_sel      - channel decoded from D2..D0
//   sgl_diff    - 1 single-ended, 0 differential
//   ch_data     - sample value, captured while sample_req is high
//   sample_req  - one-clk request/capture strobe
//   busy        - start bit seen, frame not yet ended/aborted
//   conv_done   - one-clk pulse after B0 has been driven

module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  output logic [2:0]        ch_sel,
  output logic              sgl_diff,
  input  logic [DATA_W-1:0] ch_data,
  output logic              sample_req,
  output logic              busy,
  output logic              conv_done
);

`ifdef MCP3008_LSB_FIRST_EN
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_CFG        = 3'd2,
    S_SAMPLE     = 3'd3,
    S_MSB        = 3'd4,
    S_LSB        = 3'd5,
    S_ZERO       = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_CFG        = 3'd2,
    S_SAMPLE     = 3'd3,
    S_MSB        = 3'd4,
    S_ZERO       = 3'd6
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // Input synchronizers and registered edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   din_q;

  logic sclk_s;
  logic cs_s;
  logic din_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;  // deselected out of reset
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      fall_q      <= ~sclk_s & sclk_prev_q;
      // din delayed alongside rise_q so the bit used is the one present at the rise
      din_q       <= din_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic [2:0]        ch_sel_q, ch_sel_d;
  logic              sgl_diff_q, sgl_diff_d;
  logic              sample_req_q, sample_req_d;
  logic              conv_done_q, conv_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cfg_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      ch_sel_q     <= '0;
      sgl_diff_q   <= 1'b0;
      sample_req_q <= 1'b0;
      conv_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      ch_sel_q     <= ch_sel_d;
      sgl_diff_q   <= sgl_diff_d;
      sample_req_q <= sample_req_d;
      conv_done_q  <= conv_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    busy_d       = busy_q;
    ch_sel_d     = ch_sel_q;
    sgl_diff_d   = sgl_diff_q;
    sample_req_d = 1'b0;
    conv_done_d  = 1'b0;

    if (cs_s) begin
      // Deselect wins over any edge seen on the same clk; the sample is dropped.
      state_d = S_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      dout_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          dout_d  = 1'b0;
          state_d = S_WAIT_START;
        end

        S_WAIT_START: begin
          dout_d = 1'b0;
          // Leading zeros before the start bit are simply skipped.
          if (rise_q && din_q) begin
            state_d = S_CFG;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end

        S_CFG: begin
          if (rise_q) begin
            if (cnt_q == 4'd3) begin
              sgl_diff_d = cfg_q[2];
              ch_sel_d   = {cfg_q[1:0], din_q};
              cnt_d      = '0;
              state_d    = S_SAMPLE;
            end else begin
              cfg_d = {cfg_q[1:0], din_q};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end

        S_SAMPLE: begin
          if (fall_q) begin
            sample_req_d = 1'b1;
            dout_d       = 1'b0;  // null bit
            cnt_d        = '0;
            state_d      = S_MSB;
          end
        end

        S_MSB: begin
          // Capture lands on the clk sample_req is high; the next fall is
          // at least several clks later, so the two never coincide.
          if (sample_req_q) begin
            shreg_d = ch_data;
          end else if (fall_q) begin
            dout_d  = shreg_q[DATA_W-1];
            // Rotate rather than shift so the word is intact again after B0
            // and can be replayed LSB first.
            shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
            if (cnt_q == 4'(DATA_W-1)) begin
              conv_done_d = 1'b1;
              cnt_d       = '0;
`ifdef MCP3008_LSB_FIRST_EN
              state_d     = S_LSB;
`else
              state_d     = S_ZERO;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end

`ifdef MCP3008_LSB_FIRST_EN
        S_LSB: begin
          if (fall_q) begin
            // B0 is not repeated: start from bit 1 and rotate right.
            dout_d  = shreg_q[1];
            shreg_d = {shreg_q[0], shreg_q[DATA_W-1:1]};
            if (cnt_q == 4'(DATA_W-2)) begin
              cnt_d   = '0;
              state_d = S_ZERO;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
`endif

        S_ZERO: begin
          if (fall_q) begin
            dout_d = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = ~cs_s;
  assign ch_sel     = ch_sel_q;
  assign sgl_diff   = sgl_diff_q;
  assign sample_req = sample_req_q;
  assign busy       = busy_q;
  assign conv_done  = conv_done_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// tb/tb_mcp3008_responder.sv - self-checking bench for mcp3008_responder

module tb_mcp3008_responder;

  localparam int SYNC_STAGES = 2;
  localparam int DATA_W      = 10;

  logic              clk;
  logic              rst_n;
  logic              spi_clk;
  logic              cs_n;
  logic              din;
  logic              dout;
  logic              dout_oe;
  logic [2:0]        ch_sel;
  logic              sgl_diff;
  logic [DATA_W-1:0] ch_data;
  logic              sample_req;
  logic              busy;
  logic              conv_done;

  int checks;
  int errors;
  int sreq_cnt;
  int cd_cnt;

  mcp3008_responder #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .cs_n      (cs_n),
    .din       (din),
    .dout      (dout),
    .dout_oe   (dout_oe),
    .ch_sel    (ch_sel),
    .sgl_diff  (sgl_diff),
    .ch_data   (ch_data),
    .sample_req(sample_req),
    .busy      (busy),
    .conv_done (conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_req) sreq_cnt++;
    if (conv_done) cd_cnt++;
  end

  // One SPI period = 8 clk: fall with new din, read dout just before the rise.
  task automatic spi_cycle(input logic d, output logic q);
    @(negedge clk);
    spi_clk = 1'b0;
    din     = d;
    repeat (4) @(negedge clk);
    q       = dout;
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Bit the master sends at cycle i: leading zeros, start, SGL/DIFF, D2..D0,
  // then don't-care (random) bits.
  function automatic logic master_bit(int i, int nlead, logic sgl, logic [2:0] ch);
    if (i < nlead) return 1'b0;
    if (i == nlead) return 1'b1;
    if (i == nlead + 1) return sgl;
    if (i <= nlead + 4) return ch[nlead + 4 - i];
    return 1'($urandom);
  endfunction

  // Reference dout stream as read at each master rise: zeros until D0 has
  // been sent, null bit, MSB-first word, optional LSB-first replay, zeros.
  function automatic void model_stream(int nlead, logic [DATA_W-1:0] data, int len,
                                       output logic exp_q[$]);
    exp_q = {};
    for (int i = 0; i <= nlead + 4; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(data[b]);
    for (int b = 1; b < DATA_W; b++) begin
`ifdef MCP3008_LSB_FIRST_EN
      exp_q.push_back(data[b]);
`else
      exp_q.push_back(1'b0);
`endif
    end
    while (exp_q.size() < len) exp_q.push_back(1'b0);
  endfunction

  task automatic end_frame();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    spi_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int nlead, input logic sgl,
                           input logic [2:0] ch, input logic [DATA_W-1:0] data);
    int   ncyc;
    int   s0, c0, bad_idx;
    logic q, busy_seen, oe_seen;
    logic got_q[$];
    logic exp_q[$];
    ncyc      = nlead + 5 + 24;
    s0        = sreq_cnt;
    c0        = cd_cnt;
    busy_seen = 1'b0;
    ch_data   = data;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    oe_seen = dout_oe;
    for (int i = 0; i < ncyc; i++) begin
      spi_cycle(master_bit(i, nlead, sgl, ch), q);
      got_q.push_back(q);
      if (i == nlead + 2 && busy) busy_seen = 1'b1;
    end
    model_stream(nlead, data, ncyc, exp_q);
    bad_idx = -1;
    for (int i = 0; i < ncyc; i++)
      if (got_q[i] !== exp_q[i] && bad_idx < 0) bad_idx = i;

    checks++;
    if (oe_seen !== 1'b1) begin
      errors++; $display("FAIL %s dout_oe: got %b want 1", name, oe_seen);
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++; $display("FAIL %s busy: got %b want 1", name, busy_seen);
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s dout_stream: bit %0d got %b want %b", name, bad_idx,
               got_q[bad_idx], exp_q[bad_idx]);
    end
    checks++;
    if (ch_sel !== ch) begin
      errors++; $display("FAIL %s ch_sel: got %0d want %0d", name, ch_sel, ch);
    end
    checks++;
    if (sgl_diff !== sgl) begin
      errors++; $display("FAIL %s sgl_diff: got %b want %b", name, sgl_diff, sgl);
    end
    checks++;
    if (sreq_cnt - s0 != 1) begin
      errors++; $display("FAIL %s sample_req_count: got %0d want 1", name, sreq_cnt - s0);
    end
    checks++;
    if (cd_cnt - c0 != 1) begin
      errors++; $display("FAIL %s conv_done_count: got %0d want 1", name, cd_cnt - c0);
    end
    end_frame();
    checks++;
    if (busy !== 1'b0 || dout_oe !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b dout_oe=%b dout=%b want 0 0 0", name, busy,
               dout_oe, dout);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, dout_oe, ch_sel, sgl_diff, sample_req, busy, conv_done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {dout, dout_oe, ch_sel, sgl_diff,
               sample_req, busy, conv_done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_ended_ch3();
    run_frame("single_ch3", 0, 1'b1, 3'd3, 10'h2A5);
  endtask

  task automatic test_leading_zeros();
    run_frame("lead_zeros", 3, 1'b0, 3'd0, 10'h3FF);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      run_frame("random", int'($urandom_range(0, 3)), 1'($urandom), 3'($urandom),
                10'($urandom));
  endtask

  task automatic test_abort();
    int   s0, c0, nlead;
    logic q;
    nlead   = 1;
    s0      = sreq_cnt;
    c0      = cd_cnt;
    ch_data = 10'h155;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    // Stop right after B6 has been read (null at nlead+5, B9 at nlead+6).
    for (int i = 0; i <= nlead + 9; i++) spi_cycle(master_bit(i, nlead, 1'b1, 3'd6), q);
    checks++;
    if (q !== ch_data[6]) begin
      errors++; $display("FAIL abort_b6: got %b want %b", q, ch_data[6]);
    end
    @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    checks++;
    if (dout_oe !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: dout_oe=%b busy=%b dout=%b want 0 0 0", dout_oe, busy, dout);
    end
    spi_clk = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cd_cnt != c0 || sreq_cnt - s0 != 1) begin
      errors++;
      $display("FAIL abort_pulses: conv_done=%0d sample_req=%0d want 0 1", cd_cnt - c0,
               sreq_cnt - s0);
    end
    run_frame("after_abort", 0, 1'b1, 3'd2, 10'h0F3);
  endtask

  task automatic test_reset_mid_frame();
    int   s0;
    logic q, any_one;
    ch_data = 10'h2C7;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i <= 7; i++) spi_cycle(master_bit(i, 0, 1'b1, 3'd5), q);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_oe, ch_sel, sgl_diff, sample_req, busy, conv_done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %b want 0", {dout, dout_oe, ch_sel, sgl_diff,
               sample_req, busy, conv_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0      = sreq_cnt;
    any_one = 1'b0;
    for (int i = 0; i < 16; i++) begin
      spi_cycle(1'b0, q);
      if (q !== 1'b0 || busy !== 1'b0) any_one = 1'b1;
    end
    checks++;
    if (any_one !== 1'b0 || sreq_cnt != s0) begin
      errors++;
      $display("FAIL reset_no_resume: activity=%b sample_req=%0d want 0 0", any_one,
               sreq_cnt - s0);
    end
    end_frame();
    run_frame("after_reset", 2, 1'b0, 3'd7, 10'h11B);
  endtask

  task automatic test_back_to_back();
    int s0, c0;
    s0 = sreq_cnt;
    c0 = cd_cnt;
    run_frame("b2b_first", 0, 1'b1, 3'd1, 10'h001);
    run_frame("b2b_second", 0, 1'b1, 3'd4, 10'h200);
    checks++;
    if (sreq_cnt - s0 != 2 || cd_cnt - c0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses: sample_req=%0d conv_done=%0d want 2 2", sreq_cnt - s0,
               cd_cnt - c0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sreq_cnt = 0;
    cd_cnt   = 0;
    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    cs_n     = 1'b1;
    din      = 1'b0;
    ch_data  = '0;
    test_reset();
    test_single_ended_ch3();
    test_leading_zeros();
    test_random();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
